// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_if
//  Description : Valid/ready operand and result bundle for pipelined_adder.
//                The master drives operands and consumes results, and the
//                slave is the adder.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipelined_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : Pipelined ripple-segment adder/subtractor. A WIDTH-bit add
//                is split into STAGES segments of WIDTH/STAGES bits. One
//                segment is resolved per stage, and the carry is registered
//                between stages. WIDTH must be a multiple of STAGES.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_adder_if.slave   bus
);
  localparam int c_SEG  = WIDTH / STAGES;
  localparam int c_LAST = STAGES - 1;

  // Single pipeline enable: every stage moves or every stage holds.
  logic w_adv;

  // Stage registers. r_a and r_b carry the operand segments that have not
  // been added yet. r_s collects the completed sum segments, and r_c is the
  // carry out of the segment that this stage resolved.
  logic             r_v [STAGES];
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];

  // Stage inputs: the bus for stage 0, and the previous register for the
  // stages after it.
  logic             w_vi [STAGES];
  logic [WIDTH-1:0] w_ai [STAGES];
  logic [WIDTH-1:0] w_bi [STAGES];
  logic [WIDTH-1:0] w_si [STAGES];
  logic             w_ci [STAGES];

  // in_ready depends only on registered state and out_ready, so no path
  // exists from in_valid to in_ready or from out_ready to out_valid.
  assign w_adv        = ~r_v[c_LAST] | bus.out_ready;
  assign bus.in_ready = w_adv;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [c_SEG:0]   w_seg;
      logic [WIDTH-1:0] w_sn;

      if (k == 0) begin : g_entry
        // Sub is folded in here. Only B' and c0 travel down the pipe.
        assign w_vi[k] = bus.in_valid;
        assign w_ai[k] = bus.A;
        assign w_bi[k] = bus.Sub ? ~bus.B : bus.B;
        assign w_ci[k] = bus.Sub ? ~bus.Cin : bus.Cin;
        assign w_si[k] = '0;
      end else begin : g_chain
        assign w_vi[k] = r_v[k-1];
        assign w_ai[k] = r_a[k-1];
        assign w_bi[k] = r_b[k-1];
        assign w_si[k] = r_s[k-1];
        assign w_ci[k] = r_c[k-1];
      end

      assign w_seg = {1'b0, w_ai[k][k*c_SEG +: c_SEG]}
                   + {1'b0, w_bi[k][k*c_SEG +: c_SEG]}
                   + {{c_SEG{1'b0}}, w_ci[k]};

      // Merge this stage's segment into the partial sum passed down the pipe.
      always_comb begin
        w_sn                     = w_si[k];
        w_sn[k*c_SEG +: c_SEG]   = w_seg[c_SEG-1:0];
      end

      // Stage register: the valid bit, the operands, the partial sum and the
      // segment carry all move together when the pipe advances.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v[k] <= 1'b0;
          r_a[k] <= '0;
          r_b[k] <= '0;
          r_s[k] <= '0;
          r_c[k] <= 1'b0;
        end else if (w_adv) begin
          r_v[k] <= w_vi[k];
          r_a[k] <= w_ai[k];
          r_b[k] <= w_bi[k];
          r_s[k] <= w_sn;
          r_c[k] <= w_seg[c_SEG];
        end
      end
    end
  endgenerate

  assign bus.out_valid = r_v[c_LAST];
  assign bus.Sum       = r_s[c_LAST];
  assign bus.Cout      = r_c[c_LAST];
  // The carry into the MSB is recovered as a ^ b' ^ sum at that bit.
  // Overflow is that carry XOR the carry out of the MSB.
  assign bus.Ovf       = r_a[c_LAST][WIDTH-1] ^ r_b[c_LAST][WIDTH-1]
                       ^ r_s[c_LAST][WIDTH-1] ^ r_c[c_LAST];
endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Scoreboard bench. Three adders (STAGES = 4, 1 and 32) share
//                one stimulus stream, and each one keeps its own queue of
//                expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;
  localparam int W  = 32;
  localparam int ND = 3;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   stamp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic [ND-1:0] ov;
  logic [ND-1:0] ir;
  logic [ND-1:0] co;
  logic [ND-1:0] of;
  logic [31:0]   sum_o [ND];

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   advcnt [ND];
  int   run    [ND];
  int   maxrun [ND];
  int   ncons  [ND];
  logic [ND-1:0] held;
  res_t heldv [ND];

  always #5 clk = ~clk;

  function automatic int stg(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
  endfunction

  generate
    for (genvar i = 0; i < ND; i++) begin : g_dut
      localparam int STG = (i == 0) ? 4 : ((i == 1) ? 1 : 32);
      pipelined_adder_if #(.WIDTH(W)) u_if ();
      assign u_if.in_valid  = in_valid;
      assign u_if.A         = a;
      assign u_if.B         = b;
      assign u_if.Cin       = cin;
      assign u_if.Sub       = sub;
      assign u_if.out_ready = out_ready;
      assign ov[i]    = u_if.out_valid;
      assign ir[i]    = u_if.in_ready;
      assign co[i]    = u_if.Cout;
      assign of[i]    = u_if.Ovf;
      assign sum_o[i] = u_if.Sum;
      pipelined_adder #(.WIDTH(W), .STAGES(STG)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
      );
    end
  endgenerate

  // Reference model built from integer arithmetic: the unsigned result gives
  // Sum and Cout, and the signed result gives Ovf.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb);
    longint sx, sy, ux, uy, c, r, u;
    longint smax, smin, two32;
    res_t o;
    smax  = 64'sd2147483647;
    smin  = -64'sd2147483648;
    two32 = 64'sd4294967296;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    c  = ci ? 64'sd1 : 64'sd0;
    if (sb) begin
      r = sx - sy - c;
      u = ux - uy - c;
      o.cout = (u >= 0);
      if (u < 0) u = u + two32;
    end else begin
      r = sx + sy + c;
      u = ux + uy + c;
      o.cout = (u >= two32);
    end
    o.sum = u[31:0];
    o.ovf = (r > smax) || (r < smin);
    return o;
  endfunction

  function automatic void push(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop(input int d, output exp_t e);
    bit ok;
    ok = 1'b0;
    e  = '{r: '0, stamp: 0};
    case (d)
      0:       if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
    return ok;
  endfunction

  // Monitor: samples every DUT on the falling edge and predicts what the
  // next rising edge will accept or deliver.
  always @(negedge clk) begin
    res_t got;
    exp_t e;
    bit   have;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
      held = '0;
      for (int d = 0; d < ND; d++) begin
        run[d]    = 0;
        advcnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        got = {sum_o[d], co[d], of[d]};
        if (held[d] && ov[d]) begin
          checks++;
          if (got !== heldv[d]) begin
            failures++;
            $display("FAIL hold_stable dut%0d got=%h want=%h", d, got, heldv[d]);
          end
        end
        held[d]  = ov[d] && !out_ready;
        heldv[d] = got;
        if (ov[d] && !out_ready) begin
          checks++;
          if (ir[d] !== 1'b0) begin
            failures++;
            $display("FAIL in_ready_stall dut%0d got=%b want=0", d, ir[d]);
          end
        end
        run[d] = ov[d] ? run[d] + 1 : 0;
        if (run[d] > maxrun[d]) maxrun[d] = run[d];
        if (ov[d] && out_ready) begin
          have = pop(d, e);
          checks++;
          ncons[d]++;
          if (!have) begin
            failures++;
            $display("FAIL unexpected_result dut%0d got=%h want=none", d, got);
          end else if (got !== e.r || (advcnt[d] - e.stamp) != stg(d)) begin
            failures++;
            $display("FAIL result dut%0d got=%h lat=%0d want=%h lat=%0d",
                     d, got, advcnt[d] - e.stamp, e.r, stg(d));
          end
        end
        if (in_valid && ir[d]) push(d, '{r: model(a, b, cin, sub), stamp: advcnt[d]});
        if (ir[d]) advcnt[d]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic ci, input logic sb);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    a = x; b = y; cin = ci; sub = sb;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = ir[0];
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=in_ready0 want=accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 300) begin
      tick();
      t++;
    end
    checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d/%0d pending want=0", q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int base [ND];
    // Check the values held while reset is asserted.
    rst_n = 1'b0;
    repeat (2) tick();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || sum_o[d] !== 32'd0 || co[d] !== 1'b0 || of[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut%0d got=v%b s%h c%b o%b want=all0",
                 d, ov[d], sum_o[d], co[d], of[d]);
      end
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ir[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready dut%0d got=%b want=1", d, ir[d]);
      end
    end

    // Directed corner cases.
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h5, 32'h7, 1'b0, 1'b1);
    send(32'h0, 32'h0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    send(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drain();

    // Back-to-back random burst of 16 operations.
    for (int d = 0; d < ND; d++) maxrun[d] = 0;
    for (int i = 0; i < 16; i++) send_rand();
    drain();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (maxrun[d] < 16) begin
        failures++;
        $display("FAIL consecutive dut%0d got=%0d want>=16", d, maxrun[d]);
      end
    end

    // Burst with the consumer stalled for 3 cycles.
    fork
      begin
        for (int i = 0; i < 12; i++) send_rand();
      end
      begin
        repeat (7) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Random gaps and random back-pressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 2) == 0) tick();
          send_rand();
        end
        done = 1'b1;
      end
      begin
        for (int t = 0; t < 1000 && !done; t++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Assert reset with operations in flight, then send one operation.
    send_rand();
    send_rand();
    send_rand();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || sum_o[d] !== 32'd0) begin
        failures++;
        $display("FAIL midreset dut%0d got=v%b s%h want=v0 s0", d, ov[d], sum_o[d]);
      end
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) base[d] = ncons[d];
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    drain();
    repeat (4) tick();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ncons[d] - base[d] != 1) begin
        failures++;
        $display("FAIL post_reset_count dut%0d got=%0d want=1", d, ncons[d] - base[d]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
